// File: rtl/counter_sched_if.sv
// counter_sched_if: requester and shared-counter signals of counter_sched
interface counter_sched_if #(
  parameter int NREQ = 4,
  parameter int CNT_W = 8
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic [NREQ*CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt_value;
  logic cnt_enable;
  logic cnt_reset;
  logic busy;
  modport master(output req, len, cnt_value, input grant, done, busy, cnt_enable, cnt_reset);
  modport slave(input req, len, cnt_value, output grant, done, busy, cnt_enable, cnt_reset);
endinterface

// File: rtl/counter_sched.sv
// counter_sched: round-robin sharing of one external up-counter; define COUNTER_SCHED_ABORT_EN to abort an interval when its req drops
module counter_sched #(
  parameter int NREQ = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  counter_sched_if.slave bus
);
  localparam int OW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DONE, ABORT} state_t;
  state_t state, state_n;
  logic [OW-1:0] owner, rr, pick, idx, owner_nx;
  logic [CNT_W-1:0] target;
  logic [NREQ-1:0] grant;
  logic any_req, at_target;
  assign any_req = |bus.req;
  assign at_target = bus.cnt_value == target;
  assign owner_nx = int'(owner) == NREQ - 1 ? '0 : owner + 1'b1;
  assign bus.grant = grant;
  assign bus.done = state == DONE ? NREQ'(1) << owner : '0;
  assign bus.busy = state != IDLE;
  assign bus.cnt_enable = state == RUN && !at_target;
  assign bus.cnt_reset = reset || state == CLEAR || state == ABORT;
  // first requester at or after the rr pointer, with wrap
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = OW'((int'(rr) + i) % NREQ);
      if (bus.req[idx]) pick = idx;
    end
  end
  // next state; an abort on dropped req overrides normal progress
  always_comb begin
    state_n = state == IDLE ? (any_req ? CLEAR : IDLE) :
              state == CLEAR ? RUN :
              state == RUN ? (at_target ? DONE : RUN) : IDLE;
`ifdef COUNTER_SCHED_ABORT_EN
    if ((state == CLEAR || state == RUN) && !bus.req[owner]) state_n = ABORT;
`endif
  end
  // state, owner/target latch at grant, rr advance after each interval
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      rr <= '0;
      target <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        owner <= pick;
        target <= bus.len[int'(pick)*CNT_W +: CNT_W];
        grant <= NREQ'(1) << pick;
      end else if (state_n == IDLE) grant <= '0;
      if (state == DONE || state == ABORT) rr <= owner_nx;
    end
endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one external 8-bit up-counter between NREQ requesters, each needing a timed interval.
- The counter has a synchronous clear and a count enable; this block drives both and watches the count value.
- The block grants one requester at a time, clears the counter, counts exactly that requester's programmed length, then pulses done.
- It sits beside the counter instance at the same hierarchy level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 8, counter width; matches the shared counter's out bus.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  asynchronous, active-high; clears all state.
- req  input  NREQ  per-requester request level; held until matching done.
- len  input  NREQ*CNT_W  packed interval lengths; slice i = len[i*CNT_W +: CNT_W]; sampled only at grant.
- cnt_value  input  CNT_W  current counter output.
- cnt_enable  output  1  counter enable.
- cnt_reset  output  1  counter synchronous clear.
- grant  output  NREQ  one-hot owner, registered.
- done  output  NREQ  one-hot, one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States:
  - IDLE, CLEAR, RUN, DONE.
  - Registers: state, owner index, target[CNT_W-1:0], rr pointer.
- Reset values:
  - state=IDLE, grant=0, done=0, busy=0, cnt_enable=0, target=0.
  - rr pointer=0, so requester 0 has highest priority first.
- cnt_reset = reset OR (state==CLEAR). It is therefore 1 throughout reset, and the counter clears on every clock edge during reset.
- cnt_enable = (state==RUN) AND (cnt_value != target). It is combinational and 0 in all other states.
- IDLE:
  - If any req bit is set, pick the first set bit searching from the rr pointer upward with wrap.
  - Latch owner and target = len slice, set grant, go to CLEAR.
  - If no req is set, stay in IDLE.
- CLEAR: lasts one cycle, with cnt_reset=1. Then go to RUN.
- RUN:
  - When cnt_value == target, go to DONE.
  - Otherwise stay; enable stays high, so the counter advances by 1 per cycle.
- DONE: lasts one cycle.
  - done[owner]=1 and grant still asserted.
  - rr pointer = owner+1 mod NREQ.
  - Next state is IDLE, with grant cleared on entering IDLE.
- Latency, with req first seen in IDLE at cycle t:
  - grant and cnt_reset high at t+1.
  - Counter reads 0 at t+2, and enable is high for exactly len cycles.
  - Counter equals len at t+2+len.
  - done pulse at t+3+len.
  - Earliest next grant at t+5+len.
- len=0: RUN sees equality immediately; zero enable cycles; done at t+3.
- len=2^CNT_W-1: the counter stops at its maximum and never wraps, because enable drops at equality.
- Simultaneous requests: only one grant at a time. The others wait, and the rr pointer guarantees each waits at most NREQ-1 intervals.
- A req bit that changes while not granted has no effect until the next IDLE arbitration.
- len changes after grant are ignored, because target is latched.
- cnt_value is trusted. Corruption by another driver is out of scope, but RUN still terminates only on equality.
- Reset asserted mid-operation:
  - Immediately returns state to IDLE and clears grant and done, asynchronously.
  - No done pulse is issued for the interrupted owner.
  - Counter is cleared via cnt_reset.
- Invariants: grant and done are each at most one-hot; done implies the same bit of grant.

Optional Feature:
- Macro: COUNTER_SCHED_ABORT_EN.
- Defined: in CLEAR or RUN, if req[owner] falls to 0, the block goes to an ABORT state for one cycle.
  - ABORT drives cnt_reset=1 and cnt_enable=0, with no done pulse.
  - grant clears on entering IDLE; the rr pointer advances past the owner.
- Undefined: dropping req mid-interval is ignored. The interval runs to completion and done pulses normally; the requester must tolerate this.

Test Plan:
- Reset, then idle: check grant=0, done=0, busy=0, cnt_enable=0, cnt_reset=1 during reset. After release with req=0 for 10 cycles, all outputs stay 0.
- Single request, req=4'b0001, len0=5:
  - grant=0001 at t+1, cnt_reset one cycle.
  - Exactly 5 cnt_enable cycles; cnt_value ends at 5.
  - done=0001 single pulse at t+8; busy falls the cycle after.
- len=0 and len=255 on requester 2:
  - len=0: done at t+3 with no enable cycles.
  - len=255: 255 enables, counter holds at 255 and does not wrap to 0.
- Contention, req=4'b1111 held, lens 1,2,3,4: grant order is 0,1,2,3,0. Each done matches its owner; no overlapping grants.
- Reset asserted mid-RUN for requester 1 at cnt_value=3: grant clears immediately, no done, counter cleared. After release, requester 0 wins first.
- With COUNTER_SCHED_ABORT_EN: drop req[2] at cnt_value=2 of len=10. No done, ABORT cycle with cnt_reset=1, next grant goes to requester 3 if pending. Without the macro, done[2] still pulses after 10 counts.
